cmd_mem_arbiter: RTL and testbench

Shares one single-port, byte-wide synchronous command RAM between the DDS sequencing controller (port A) and the host loader (port B). The RAM is split into two circular buffers. The lower half is the program FIFO: B writes, A reads. The upper half is the result FIFO: A writes, B reads. Each port uses the controller's level-request / single-cycle-done byte handshake, and the block sits between the controller's mem_* signals and the RAM macro.

---
 rtl/cmd_mem_arbiter_if.sv | 52 +++++
 rtl/cmd_mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_cmd_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_mem_arbiter_if.sv
// Signal bundle between the DDS controller (port A), the host loader (port B),
// the shared command RAM and the arbiter that sits in the middle.
interface cmd_mem_arbiter_if #(
    parameter int ADDR_W = 10
);
    // Port A: controller, reads the program FIFO and writes the result FIFO
    logic              a_rclk;
    logic              a_wclk;
    logic [7:0]        a_din;
    logic [7:0]        a_dout;
    logic              a_done;

    // Port B: host, writes the program FIFO and reads the result FIFO
    logic              b_rd;
    logic              b_wr;
    logic [7:0]        b_din;
    logic [7:0]        b_dout;
    logic              b_done;
    logic              b_flush;

    // RAM macro side
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;

    // Occupancy status
    logic [ADDR_W-1:0] prog_level;
    logic [ADDR_W-1:0] res_level;

    // The arbiter's view
    modport slave (
        input  a_rclk, a_wclk, a_din,
        output a_dout, a_done,
        input  b_rd, b_wr, b_din, b_flush,
        output b_dout, b_done,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output prog_level, res_level
    );

    // The combined view of controller, host and RAM
    modport master (
        output a_rclk, a_wclk, a_din,
        input  a_dout, a_done,
        output b_rd, b_wr, b_din, b_flush,
        input  b_dout, b_done,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  prog_level, res_level
    );
endinterface

// File: rtl/cmd_mem_arbiter.sv
// Shares one single-port byte RAM between controller (A) and host (B) as two
// circular FIFOs: lower half program (B->A), upper half result (A->B).
module cmd_mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    cmd_mem_arbiter_if.slave bus,
    output logic [1:0]       dbg_state
);

    // Handshake: a port holds its request level high; the arbiter answers with
    // exactly one single-cycle done per request edge. A request that cannot be
    // served (empty source / full target) is simply held with no side effect.

    localparam int PW = ADDR_W - 1;
    localparam logic [ADDR_W-1:0] HALF    = {1'b1, {(ADDR_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] pwp, prp, rwp, rrp;
    logic [ADDR_W-1:0] prog_cnt, res_cnt;
    logic [ADDR_W-1:0] prog_level_q, res_level_q;

    logic              armed_a, armed_b;
    logic              last_b;
    logic              cur_b, cur_rd;
    logic              flush_pend;

    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [7:0]        ram_wdata_q;
    logic [7:0]        a_dout_q, b_dout_q;
    logic              a_done_q, b_done_q;

    logic              a_req, b_req;
    logic              a_elig, b_elig;
    logic              grant, grant_b;
    logic              do_flush, finish, capture;
    logic              sel_rd;
    logic [ADDR_W-1:0] sel_addr;
    logic [7:0]        sel_wdata;

    assign prog_cnt = pwp - prp;
    assign res_cnt  = rwp - rrp;

    // The done mask keeps a port from being re-granted in its own done cycle,
    // before the armed flag has had a chance to clear.
    always_comb begin
        a_req  = bus.a_rclk | bus.a_wclk;
        b_req  = bus.b_rd | bus.b_wr;
        a_elig = armed_a & ~a_done_q & a_req &
                 (bus.a_rclk ? (prog_cnt != '0) : (res_cnt < HALF));
        b_elig = armed_b & ~b_done_q & b_req &
                 (bus.b_rd ? (res_cnt != '0) : (prog_cnt < HALF));
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_b    = 1'b0;
        do_flush   = 1'b0;
        finish     = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.b_flush || flush_pend) begin
                    do_flush = 1'b1;
                end else if (a_elig || b_elig) begin
                    grant      = 1'b1;
                    // last_b set means B won last time, so a tie goes to A
                    grant_b    = b_elig & (~a_elig | ~last_b);
                    state_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cur_rd) begin
                    state_next = S_CAPTURE;
                end else begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_CAPTURE: begin
                capture    = 1'b1;
                finish     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Address/data for whichever port wins this cycle; read has priority
    // over write within a port.
    always_comb begin
        sel_rd    = grant_b ? bus.b_rd : bus.a_rclk;
        sel_wdata = grant_b ? bus.b_din : bus.a_din;
        if (!grant_b) begin
            sel_addr = bus.a_rclk ? {1'b0, prp[PW-1:0]} : {1'b1, rwp[PW-1:0]};
        end else begin
            sel_addr = bus.b_rd   ? {1'b1, rrp[PW-1:0]} : {1'b0, pwp[PW-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pwp          <= '0;
            prp          <= '0;
            rwp          <= '0;
            rrp          <= '0;
            prog_level_q <= '0;
            res_level_q  <= '0;
            armed_a      <= 1'b1;
            armed_b      <= 1'b1;
            last_b       <= 1'b1;
            cur_b        <= 1'b0;
            cur_rd       <= 1'b0;
            flush_pend   <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= '0;
            a_dout_q     <= '0;
            b_dout_q     <= '0;
            a_done_q     <= 1'b0;
            b_done_q     <= 1'b0;
        end else begin
            state        <= state_next;
            prog_level_q <= prog_cnt;
            res_level_q  <= res_cnt;
            a_done_q     <= finish & ~cur_b;
            b_done_q     <= finish & cur_b;

            if (grant) begin
                ram_addr_q  <= sel_addr;
                ram_we_q    <= ~sel_rd;
                ram_wdata_q <= sel_wdata;
                cur_b       <= grant_b;
                cur_rd      <= sel_rd;
                last_b      <= grant_b;
            end else begin
                ram_we_q    <= 1'b0;
            end

            if (capture) begin
                if (cur_b) b_dout_q <= bus.ram_rdata;
                else       a_dout_q <= bus.ram_rdata;
            end

            if (do_flush) begin
                pwp <= '0;
                prp <= '0;
                rwp <= '0;
                rrp <= '0;
            end else if (finish) begin
                case ({cur_b, cur_rd})
                    2'b01:   prp <= prp + PTR_ONE;
                    2'b00:   rwp <= rwp + PTR_ONE;
                    2'b11:   rrp <= rrp + PTR_ONE;
                    default: pwp <= pwp + PTR_ONE;
                endcase
            end

            // A flush seen while busy waits for the first IDLE cycle
            flush_pend <= do_flush ? 1'b0 : (flush_pend | bus.b_flush);

            // Re-arm on a sampled-low request; disarm when the done goes out
            if (!a_req)        armed_a <= 1'b1;
            else if (a_done_q) armed_a <= 1'b0;
            if (!b_req)        armed_b <= 1'b1;
            else if (b_done_q) armed_b <= 1'b0;
        end
    end

    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.a_dout     = a_dout_q;
    assign bus.a_done     = a_done_q;
    assign bus.b_dout     = b_dout_q;
    assign bus.b_done     = b_done_q;
    assign bus.prog_level = prog_level_q;
    assign bus.res_level  = res_level_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_cmd_mem_arbiter.sv
// Directed bench for cmd_mem_arbiter with a behavioural RAM and per-FIFO
// expected-byte queues.
module tb_cmd_mem_arbiter;
    localparam int AW = 4;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    logic [7:0] mem [16];

    logic [7:0] prog_q [$];
    logic [7:0] res_q  [$];

    int errors;
    int checks;

    cmd_mem_arbiter_if #(.ADDR_W(AW)) bus ();

    cmd_mem_arbiter #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=no done expected=done within budget", tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.a_rclk = 0; bus.a_wclk = 0; bus.a_din = 0;
        bus.b_rd = 0; bus.b_wr = 0; bus.b_din = 0; bus.b_flush = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prog_q.delete();
        res_q.delete();
    endtask

    task automatic wait_done(input bit port_b, input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((port_b ? bus.b_done : bus.a_done) === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) timeout(port_b ? "b_done_wait" : "a_done_wait");
    endtask

    task automatic b_write(input logic [7:0] d);
        int lat;
        bus.b_wr = 1; bus.b_din = d;
        prog_q.push_back(d);
        wait_done(1, 30, lat);
        bus.b_wr = 0;
        @(negedge clk);
    endtask

    task automatic a_write(input logic [7:0] d);
        int lat;
        bus.a_wclk = 1; bus.a_din = d;
        res_q.push_back(d);
        wait_done(0, 30, lat);
        bus.a_wclk = 0;
        @(negedge clk);
    endtask

    task automatic a_read(output int lat);
        logic [7:0] exp;
        bus.a_rclk = 1;
        wait_done(0, 30, lat);
        exp = (prog_q.size() > 0) ? prog_q.pop_front() : 8'hxx;
        check("a_dout", {24'd0, bus.a_dout}, {24'd0, exp});
        bus.a_rclk = 0;
        @(negedge clk);
        check("a_done_width", {31'd0, bus.a_done}, 32'd0);
    endtask

    task automatic b_read();
        int lat;
        logic [7:0] exp;
        bus.b_rd = 1;
        wait_done(1, 30, lat);
        exp = (res_q.size() > 0) ? res_q.pop_front() : 8'hxx;
        check("b_dout", {24'd0, bus.b_dout}, {24'd0, exp});
        bus.b_rd = 0;
        @(negedge clk);
    endtask

    // Raise an A request and a B write together and record both done latencies
    task automatic tie(input bit a_rd, input logic [7:0] a_data, input logic [7:0] b_data,
                       input int exp_a, input int exp_b);
        int a_lat, b_lat;
        logic [7:0] exp;
        a_lat = -1; b_lat = -1;
        if (a_rd) bus.a_rclk = 1;
        else begin
            bus.a_wclk = 1; bus.a_din = a_data;
            res_q.push_back(a_data);
        end
        bus.b_wr = 1; bus.b_din = b_data;
        prog_q.push_back(b_data);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.a_done === 1'b1 && a_lat < 0) begin
                a_lat = i;
                bus.a_rclk = 0; bus.a_wclk = 0;
                if (a_rd) begin
                    exp = prog_q.pop_front();
                    check("tie_a_dout", {24'd0, bus.a_dout}, {24'd0, exp});
                end
            end
            if (bus.b_done === 1'b1 && b_lat < 0) begin
                b_lat = i;
                bus.b_wr = 0;
            end
            if (a_lat >= 0 && b_lat >= 0) break;
        end
        bus.a_rclk = 0; bus.a_wclk = 0; bus.b_wr = 0;
        check("tie_a_lat", a_lat, exp_a);
        check("tie_b_lat", b_lat, exp_b);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int seen;
        logic [7:0] exp;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        do_reset();

        // Reset state
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        check("rst_ram_addr", {28'd0, bus.ram_addr}, 32'd0);
        check("rst_a_done", {31'd0, bus.a_done}, 32'd0);
        check("rst_b_done", {31'd0, bus.b_done}, 32'd0);
        check("rst_prog_level", {28'd0, bus.prog_level}, 32'd0);
        check("rst_res_level", {28'd0, bus.res_level}, 32'd0);
        check("rst_a_dout", {24'd0, bus.a_dout}, 32'd0);

        // Arbitration: first tie after reset goes to A, then round-robin
        tie(1'b0, 8'hA1, 8'hB1, 2, 4);
        a_read(lat);
        tie(1'b0, 8'hA2, 8'hB2, 4, 2);
        tie(1'b1, 8'h00, 8'hB3, 5, 2);

        // Basic program FIFO traffic with read latency
        do_reset();
        b_write(8'h11);
        b_write(8'h22);
        b_write(8'h33);
        for (int i = 0; i < 3; i++) begin
            a_read(lat);
            check("a_read_lat", lat, 3);
        end
        repeat (2) @(negedge clk);
        check("prog_level_drained", {28'd0, bus.prog_level}, 32'd0);

        // Read stalls on empty program FIFO until B supplies a byte
        do_reset();
        bus.a_rclk = 1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.a_done === 1'b1) seen++;
        end
        check("empty_stall_dones", seen, 0);
        b_write(8'h5A);
        wait_done(0, 10, lat);
        exp = prog_q.pop_front();
        check("empty_stall_dout", {24'd0, bus.a_dout}, {24'd0, exp});
        bus.a_rclk = 0;
        @(negedge clk);

        // Result FIFO full stall and in-order data across the pointer wrap
        do_reset();
        for (int i = 0; i < 8; i++) a_write(8'hC0 + 8'(i));
        @(negedge clk);
        check("res_level_full", {28'd0, bus.res_level}, 32'd8);
        bus.a_wclk = 1; bus.a_din = 8'h99;
        res_q.push_back(8'h99);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.a_done === 1'b1) seen++;
        end
        check("full_stall_dones", seen, 0);
        check("full_stall_level", {28'd0, bus.res_level}, 32'd8);
        b_read();
        wait_done(0, 10, lat);
        bus.a_wclk = 0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            b_read();
            a_write(8'($urandom_range(0, 255)));
        end
        @(negedge clk);
        check("res_level_after_wrap", {28'd0, bus.res_level}, 32'd8);

        // Flush during A's CAPTURE
        do_reset();
        b_write(8'h77);
        b_write(8'h88);
        bus.a_rclk = 1;
        repeat (2) @(negedge clk);
        check("flush_in_capture", {30'd0, dbg_state}, 32'd2);
        bus.b_flush = 1;
        @(negedge clk);
        bus.b_flush = 0;
        check("flush_a_done", {31'd0, bus.a_done}, 32'd1);
        exp = prog_q.pop_front();
        check("flush_a_dout", {24'd0, bus.a_dout}, {24'd0, exp});
        bus.a_rclk = 0;
        prog_q.delete();
        repeat (3) @(negedge clk);
        check("flush_prog_level", {28'd0, bus.prog_level}, 32'd0);
        check("flush_res_level", {28'd0, bus.res_level}, 32'd0);
        bus.b_wr = 1; bus.b_din = 8'h99;
        @(negedge clk);
        check("flush_wr_we", {31'd0, bus.ram_we}, 32'd1);
        check("flush_wr_addr", {28'd0, bus.ram_addr}, 32'd0);
        check("flush_wr_data", {24'd0, bus.ram_wdata}, 32'h99);
        wait_done(1, 10, lat);
        bus.b_wr = 0;
        repeat (3) @(negedge clk);
        check("flush_then_level", {28'd0, bus.prog_level}, 32'd1);

        // Held request gives exactly one access
        do_reset();
        b_write(8'h01);
        b_write(8'h02);
        bus.a_rclk = 1;
        wait_done(0, 10, lat);
        exp = prog_q.pop_front();
        check("held_first_dout", {24'd0, bus.a_dout}, {24'd0, exp});
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.a_done === 1'b1) seen++;
        end
        check("held_extra_dones", seen, 0);
        check("held_dout_kept", {24'd0, bus.a_dout}, {24'd0, exp});
        check("held_prog_level", {28'd0, bus.prog_level}, 32'd1);
        bus.a_rclk = 0;
        @(negedge clk);
        a_read(lat);

        // Reset during a write aborts it
        do_reset();
        bus.b_wr = 1; bus.b_din = 8'h42;
        @(negedge clk);
        check("abort_we_before", {31'd0, bus.ram_we}, 32'd1);
        rst = 1'b1;
        bus.b_wr = 0;
        @(negedge clk);
        check("abort_we_after", {31'd0, bus.ram_we}, 32'd0);
        check("abort_no_done", {31'd0, bus.b_done}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_prog_level", {28'd0, bus.prog_level}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end

endmodule
